// File: rtl/vga_char_scanout.sv
// 640x480@60 VGA scanout: free-running raster counters, per-pixel character-cell
// read requests, and a two-stage pipeline aligning the buffer result with the syncs.
module vga_char_scanout #(
  parameter int          p_h_active   = 640,
  parameter int          p_h_front    = 16,
  parameter int          p_h_sync     = 96,
  parameter int          p_h_back     = 48,
  parameter int          p_v_active   = 480,
  parameter int          p_v_front    = 10,
  parameter int          p_v_sync     = 2,
  parameter int          p_v_back     = 33,
  parameter logic [11:0] p_fg_rgb     = 12'hFFF,
  parameter logic [11:0] p_bg_rgb     = 12'h000,
  parameter logic [11:0] p_border_rgb = 12'h008
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] read_hchar,
  output logic [5:0] read_vchar,
  output logic [2:0] read_hoffset,
  output logic [2:0] read_voffset,
  input  logic       read_lit,
  input  logic       out_of_bounds,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start
);

  localparam int h_total = p_h_active + p_h_front + p_h_sync + p_h_back;
  localparam int v_total = p_v_active + p_v_front + p_v_sync + p_v_back;
  localparam int hw      = $clog2(h_total);
  localparam int vw      = $clog2(v_total);

  localparam logic [hw-1:0] h_last   = hw'(h_total - 1);
  localparam logic [hw-1:0] h_act    = hw'(p_h_active);
  localparam logic [hw-1:0] hs_start = hw'(p_h_active + p_h_front);
  localparam logic [hw-1:0] hs_end   = hw'(p_h_active + p_h_front + p_h_sync - 1);
  localparam logic [vw-1:0] v_last   = vw'(v_total - 1);
  localparam logic [vw-1:0] v_act    = vw'(p_v_active);
  localparam logic [vw-1:0] vs_start = vw'(p_v_active + p_v_front);
  localparam logic [vw-1:0] vs_end   = vw'(p_v_active + p_v_front + p_v_sync - 1);

  logic [hw-1:0] hcount;
  logic [vw-1:0] vcount;
  logic          active0, hs0, vs0, first0;
  logic          active1, hs1, vs1, first1;
  logic [11:0]   rgb_next;
  logic [11:0]   rgb_q;

  // stage 0: raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == h_last) begin
      hcount <= '0;
      vcount <= (vcount == v_last) ? '0 : vcount + vw'(1);
    end else begin
      hcount <= hcount + hw'(1);
    end
  end

  // vsync follows vcount, so it only ever changes at hcount == 0
  always_comb begin
    active0 = (hcount < h_act) && (vcount < v_act);
    hs0     = !((hcount >= hs_start) && (hcount <= hs_end));
    vs0     = !((vcount >= vs_start) && (vcount <= vs_end));
    first0  = (hcount == '0) && (vcount == '0);
  end

  // blanking row 6'h3F lies beyond the last visible character row
  always_comb begin
    read_hchar   = 7'h7F;
    read_vchar   = 6'h3F;
    read_hoffset = 3'd0;
    read_voffset = 3'd0;
    if (active0) begin
      read_hchar   = 7'(hcount >> 3);
      read_vchar   = 6'(vcount >> 3);
      read_hoffset = hcount[2:0];
      read_voffset = vcount[2:0];
    end
  end

  // stage 1: buffer result for this pixel arrives while these are held
  always_ff @(posedge clk) begin
    if (rst) begin
      active1 <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      first1  <= 1'b0;
    end else begin
      active1 <= active0;
      hs1     <= hs0;
      vs1     <= vs0;
      first1  <= first0;
    end
  end

  always_comb begin
    rgb_next = 12'h000;
    if (active1) begin
      if (out_of_bounds) rgb_next = p_border_rgb;
      else if (read_lit) rgb_next = p_fg_rgb;
      else               rgb_next = p_bg_rgb;
    end
  end

  // stage 2: output registers, syncs kept aligned with colour
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      rgb_q       <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= hs1;
      vga_vsync   <= vs1;
      rgb_q       <= rgb_next;
      frame_start <= first1;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule
